// File: rtl/snake_body_tracker.sv
// snake_body_tracker: shifting snake body with growth, sticky self-collision and optional probe (SNAKE_BODY_PROBE_EN).
module snake_body_tracker #(
   parameter int MAX_LEN  = 16,
   parameter int COORD_W  = 11,
   parameter int INIT_LEN = 3,
   parameter int START_X  = 0,
   parameter int START_Y  = 0,
   localparam int LW      = $clog2(MAX_LEN + 1)
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       step,
   input  logic                       grow,
   input  logic [COORD_W-1:0]         head_x,
   input  logic [COORD_W-1:0]         head_y,
   input  logic [COORD_W-1:0]         probe_x,
   input  logic [COORD_W-1:0]         probe_y,
   output logic [MAX_LEN*COORD_W-1:0] body_x,
   output logic [MAX_LEN*COORD_W-1:0] body_y,
   output logic [MAX_LEN-1:0]         active,
   output logic [LW-1:0]              length,
   output logic                       full,
   output logic                       collision,
   output logic                       probe_hit
);
   typedef enum logic {RUN, DEAD} state_t;
   state_t             state;
   logic [COORD_W-1:0] seg_x [MAX_LEN];
   logic [COORD_W-1:0] seg_y [MAX_LEN];
   logic               pending_grow, grow_now, hit;
   logic [LW-1:0]      lim;

   assign full     = length == LW'(MAX_LEN);
   assign grow_now = (grow | pending_grow) & ~full;
   // when not growing the tail vacates on this step, so it is excluded
   assign lim      = grow_now ? length : length - LW'(1);

   always_comb begin
      hit = 1'b0;
      for (int j = 0; j < MAX_LEN; j++)
         if (LW'(j) < lim && seg_x[j] == head_x && seg_y[j] == head_y) hit = 1'b1;
   end

   for (genvar i = 0; i < MAX_LEN; i++) begin : g_out
      assign body_x[i*COORD_W +: COORD_W] = seg_x[i];
      assign body_y[i*COORD_W +: COORD_W] = seg_y[i];
      assign active[i] = LW'(i) < length;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < MAX_LEN; i++) begin
            seg_x[i] <= COORD_W'(START_X);
            seg_y[i] <= COORD_W'(START_Y);
         end
         length       <= LW'(INIT_LEN);
         pending_grow <= 1'b0;
         collision    <= 1'b0;
         state        <= RUN;
      end else if (state == RUN) begin
         if (step) begin
            seg_x[0] <= head_x;
            seg_y[0] <= head_y;
            for (int i = 1; i < MAX_LEN; i++) begin
               seg_x[i] <= seg_x[i-1];
               seg_y[i] <= seg_y[i-1];
            end
            if (grow_now) length <= length + LW'(1);
            pending_grow <= 1'b0;
            if (hit) begin
               collision <= 1'b1;
               state     <= DEAD;
            end
         end else if (grow && !full) begin
            pending_grow <= 1'b1;
         end
      end
   end

`ifdef SNAKE_BODY_PROBE_EN
   logic probe_match;
   always_comb begin
      probe_match = 1'b0;
      for (int i = 0; i < MAX_LEN; i++)
         if (active[i] && seg_x[i] == probe_x && seg_y[i] == probe_y) probe_match = 1'b1;
   end
   always_ff @(posedge clock or posedge reset)
      if (reset) probe_hit <= 1'b0;
      else probe_hit <= probe_match;
`else
   logic unused_probe;
   assign unused_probe = ^{probe_x, probe_y};
   assign probe_hit    = 1'b0;
`endif
endmodule
